// File: rtl/spimem_arb2.sv
// rtl/spimem_arb2.sv - two-requester round-robin arbiter in front of one QSPI flash MEM port
//
// Purpose:
//   Lets two PicoRV32 packed MEM bus requesters share a single flash peripheral.
//   Only requests whose addr[31:24] equals BASE_ADDR are considered. The winner's
//   request is registered onto the downstream bus, and one registered ready pulse
//   is returned to it. A BUSY-cycle timeout forces a response if the flash never
//   answers.
//
// Packed layouts:
//   fwd (69 bits) = {wdata[31:0], wstrb[3:0], valid, addr[31:0]}
//   ret (33 bits) = {ready, rdata[31:0]}
//
// Ports:
//   clk            in   1   system clock
//   resetn         in   1   asynchronous active-low reset
//   m0_packed_fwd  in   69  requester 0 forward bus
//   m0_packed_ret  out  33  requester 0 return bus (zero except in its RESP cycle)
//   m1_packed_fwd  in   69  requester 1 forward bus
//   m1_packed_ret  out  33  requester 1 return bus (zero except in its RESP cycle)
//   s_packed_fwd   out  69  forward bus to the flash peripheral (zero when not valid)
//   s_packed_ret   in   33  return bus from the flash peripheral
//   busy           out  1   high in BUSY or RESP
//   grant          out  1   index of the current/last winner
//   timeout_count  out  8   saturating count of timed-out accesses

module spimem_arb2 #(
  parameter logic [7:0]  BASE_ADDR    = 8'h00,
  parameter logic [15:0] TIMEOUT      = 16'd4096,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [68:0] m0_packed_fwd,
  output logic [32:0] m0_packed_ret,
  input  logic [68:0] m1_packed_fwd,
  output logic [32:0] m1_packed_ret,
  output logic [68:0] s_packed_fwd,
  input  logic [32:0] s_packed_ret,
  output logic        busy,
  output logic        grant,
  output logic [7:0]  timeout_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q,  state_d;
  logic        grant_q,  grant_d;
  logic        last_q,   last_d;
  logic [1:0]  served_q, served_d;
  logic [68:0] s_fwd_q,  s_fwd_d;
  logic [32:0] m0_ret_q, m0_ret_d;
  logic [32:0] m1_ret_q, m1_ret_d;
  logic [15:0] timer_q,  timer_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;

  logic        elig0;
  logic        elig1;
  logic        win;
  logic        done;
  logic [32:0] resp;

  // A port served in the previous cycle is masked: a registered master still
  // shows its old valid for one cycle after seeing ready.
  assign elig0 = m0_packed_fwd[32] && (m0_packed_fwd[31:24] == BASE_ADDR) && !served_q[0];
  assign elig1 = m1_packed_fwd[32] && (m1_packed_fwd[31:24] == BASE_ADDR) && !served_q[1];

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    served_d  = 2'b00;
    s_fwd_d   = s_fwd_q;
    m0_ret_d  = m0_ret_q;
    m1_ret_d  = m1_ret_q;
    timer_d   = timer_q;
    tmo_cnt_d = tmo_cnt_q;
    win       = 1'b0;
    done      = 1'b0;
    resp      = 33'd0;

    case (state_q)
      ST_IDLE: begin
        timer_d = 16'd0;
        if (elig0 || elig1) begin
          // Contention goes to the port that did not win last; last_q resets
          // to 1 so requester 0 wins the first contended grant.
          win     = (elig0 && elig1) ? ~last_q : elig1;
          grant_d = win;
          last_d  = win;
          // The winner's valid bit is known to be 1, so the whole packed word
          // is captured as-is and held until the access completes.
          s_fwd_d = win ? m1_packed_fwd : m0_packed_fwd;
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        timer_d = timer_q + 16'd1;
        // A real ready takes priority over a coincident timeout.
        if (s_packed_ret[32]) begin
          resp = {1'b1, s_packed_ret[31:0]};
          done = 1'b1;
        end else if ((TIMEOUT != 16'd0) && (timer_q == (TIMEOUT - 16'd1))) begin
          resp = {1'b1, TIMEOUT_DATA};
          done = 1'b1;
          if (tmo_cnt_q != 8'hFF) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
          end
        end
        if (done) begin
          s_fwd_d = 69'd0;
          state_d = ST_RESP;
          if (grant_q) begin
            m1_ret_d = resp;
          end else begin
            m0_ret_d = resp;
          end
        end
      end

      ST_RESP: begin
        // Response is a single-cycle pulse, issued whether or not the winner
        // still holds valid.
        m0_ret_d = 33'd0;
        m1_ret_d = 33'd0;
        timer_d  = 16'd0;
        served_d = grant_q ? 2'b10 : 2'b01;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d  = ST_IDLE;
        s_fwd_d  = 69'd0;
        m0_ret_d = 33'd0;
        m1_ret_d = 33'd0;
        timer_d  = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      served_q  <= 2'b00;
      s_fwd_q   <= 69'd0;
      m0_ret_q  <= 33'd0;
      m1_ret_q  <= 33'd0;
      timer_q   <= 16'd0;
      tmo_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      served_q  <= served_d;
      s_fwd_q   <= s_fwd_d;
      m0_ret_q  <= m0_ret_d;
      m1_ret_q  <= m1_ret_d;
      timer_q   <= timer_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign m0_packed_ret = m0_ret_q;
  assign m1_packed_ret = m1_ret_q;
  assign s_packed_fwd  = s_fwd_q;
  assign busy          = (state_q != ST_IDLE);
  assign grant         = grant_q;
  assign timeout_count = tmo_cnt_q;

endmodule

// File: tb/tb_spimem_arb2.sv
// tb/tb_spimem_arb2.sv - self-checking bench for spimem_arb2

module tb_spimem_arb2;

  logic        clk = 1'b0;
  logic        resetn;
  logic [68:0] m0_fwd;
  logic [68:0] m1_fwd;
  logic [68:0] s_fwd;
  logic [32:0] m0_ret;
  logic [32:0] m1_ret;
  logic [32:0] s_ret;
  logic        busy;
  logic        grant;
  logic [7:0]  tmo_cnt;

  always #5 clk = ~clk;

  spimem_arb2 #(
    .BASE_ADDR    (8'h00),
    .TIMEOUT      (16'd16),
    .TIMEOUT_DATA (32'hDEADBEEF)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .m0_packed_fwd (m0_fwd),
    .m0_packed_ret (m0_ret),
    .m1_packed_fwd (m1_fwd),
    .m1_packed_ret (m1_ret),
    .s_packed_fwd  (s_fwd),
    .s_packed_ret  (s_ret),
    .busy          (busy),
    .grant         (grant),
    .timeout_count (tmo_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic [31:0] mon_data;

  localparam logic [31:0] ADDR_KEY = 32'h5A5A0000;

  // Slave model: ready once it has seen valid for more than slave_delay cycles;
  // slave_delay < 0 means it never answers.
  int          slave_delay = -1;
  bit          slave_use_addr = 1'b0;
  logic [31:0] slave_data = 32'd0;
  int          busy_cnt;
  logic [68:0] cap_fwd;

  function automatic logic [68:0] mk_fwd(input logic [31:0] addr, input logic [31:0] wdata,
                                         input logic [3:0] wstrb, input logic valid);
    return {wdata, wstrb, valid, addr};
  endfunction

  initial begin
    s_ret    = 33'd0;
    busy_cnt = 0;
    cap_fwd  = 69'd0;
    forever begin
      @(posedge clk);
      #1;
      s_ret = 33'd0;
      if (s_fwd[32] === 1'b1) begin
        busy_cnt++;
        if (busy_cnt == 1) cap_fwd = s_fwd;
        if (slave_delay >= 0 && busy_cnt > slave_delay)
          s_ret = {1'b1, slave_use_addr ? (s_fwd[31:0] ^ ADDR_KEY) : slave_data};
      end else begin
        busy_cnt = 0;
      end
    end
  end

  // Scoreboard monitor: every ready pulse must match the next expected entry.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (m0_ret[32] === 1'b1 || m1_ret[32] === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ready: m0_ret=%h m1_ret=%h, required no ready", m0_ret, m1_ret);
        end else begin
          mon_e = exp_q.pop_front();
          if ({m1_ret[32], m0_ret[32]} !== (mon_e.port ? 2'b10 : 2'b01)) begin
            n_fail++;
            $display("FAIL ret_port: ready bits m1/m0=%b%b, required port %0d only",
                     m1_ret[32], m0_ret[32], mon_e.port);
          end
          mon_data = mon_e.port ? m1_ret[31:0] : m0_ret[31:0];
          n_checks++;
          if (mon_data !== mon_e.data) begin
            n_fail++;
            $display("FAIL ret_data: got %h, required %h", mon_data, mon_e.data);
          end
          n_checks++;
          if (grant !== mon_e.port) begin
            n_fail++;
            $display("FAIL ret_grant: got %0d, required %0d", grant, mon_e.port);
          end
          n_checks++;
          if ((mon_e.port ? m0_ret : m1_ret) !== 33'd0) begin
            n_fail++;
            $display("FAIL other_ret_zero: got %h, required 0", mon_e.port ? m0_ret : m1_ret);
          end
        end
      end else begin
        n_checks++;
        if (m0_ret !== 33'd0 || m1_ret !== 33'd0) begin
          n_fail++;
          $display("FAIL ret_idle: m0_ret=%h m1_ret=%h, required 0", m0_ret, m1_ret);
        end
      end
      n_checks++;
      if (s_fwd[32] !== 1'b1 && s_fwd !== 69'd0) begin
        n_fail++;
        $display("FAIL s_fwd_idle: got %h, required 0", s_fwd);
      end
    end
  end

  task automatic test_reset();
    resetn = 1'b0;
    m0_fwd = 69'd0;
    m1_fwd = 69'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (m0_ret !== 33'd0 || m1_ret !== 33'd0) begin
      n_fail++;
      $display("FAIL reset_ret: m0=%h m1=%h, required 0", m0_ret, m1_ret);
    end
    n_checks++;
    if (s_fwd !== 69'd0) begin
      n_fail++;
      $display("FAIL reset_s_fwd: got %h, required 0", s_fwd);
    end
    n_checks++;
    if (busy !== 1'b0 || grant !== 1'b0 || tmo_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_status: busy=%b grant=%b tmo=%h, required 0 0 00", busy, grant, tmo_cnt);
    end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_alternation();
    int n;
    exp_t e;
    slave_delay    = 1;
    slave_use_addr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e.port = 1'b0; e.data = 32'h00000100 ^ ADDR_KEY; exp_q.push_back(e);
      e.port = 1'b1; e.data = 32'h00000200 ^ ADDR_KEY; exp_q.push_back(e);
    end
    @(negedge clk);
    m0_fwd = mk_fwd(32'h00000100, 32'd0, 4'h0, 1'b1);
    m1_fwd = mk_fwd(32'h00000200, 32'd0, 4'h0, 1'b1);
    n = 0;
    for (int c = 0; c < 300 && n < 8; c++) begin
      @(negedge clk);
      if (m0_ret[32] === 1'b1 || m1_ret[32] === 1'b1) begin
        n++;
        if (n == 8) begin
          m0_fwd = 69'd0;
          m1_fwd = 69'd0;
        end
      end
    end
    m0_fwd = 69'd0;
    m1_fwd = 69'd0;
    n_checks++;
    if (n !== 8) begin
      n_fail++;
      $display("FAIL alt_count: got %0d responses, required 8", n);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL alt_pending: %0d expected responses left, required 0", exp_q.size());
    end
  endtask

  task automatic test_read();
    int   nvalid;
    bit   got;
    exp_t e;
    slave_delay    = 3;
    slave_use_addr = 1'b0;
    slave_data     = 32'h12345678;
    e.port = 1'b0; e.data = 32'h12345678; exp_q.push_back(e);
    @(negedge clk);
    m0_fwd = mk_fwd(32'h00000010, 32'd0, 4'h0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (s_fwd[32] !== 1'b1 || s_fwd[31:0] !== 32'h00000010 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL read_s_valid: valid=%b addr=%h busy=%b, required 1 00000010 1",
               s_fwd[32], s_fwd[31:0], busy);
    end
    nvalid = 1;
    got    = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (s_fwd[32] === 1'b1) nvalid++;
      if (m0_ret[32] === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    m0_fwd = 69'd0;
    n_checks++;
    if (!got || nvalid != 4) begin
      n_fail++;
      $display("FAIL read_latency: got=%0d s_valid_cycles=%0d, required 1 4", got, nvalid);
    end
  endtask

  task automatic test_write();
    bit          got;
    exp_t        e;
    logic [68:0] ew;
    slave_delay    = 0;
    slave_use_addr = 1'b0;
    slave_data     = 32'h0BADF00D;
    e.port = 1'b1; e.data = 32'h0BADF00D; exp_q.push_back(e);
    ew = mk_fwd(32'h000FFFFC, 32'hA5A5A5A5, 4'hF, 1'b1);
    @(negedge clk);
    m1_fwd = ew;
    got = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (m1_ret[32] === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    m1_fwd = 69'd0;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL write_ready: no ready within 50 cycles, required one");
    end
    n_checks++;
    if (cap_fwd !== ew) begin
      n_fail++;
      $display("FAIL write_fields: got %h, required %h", cap_fwd, ew);
    end
  endtask

  task automatic test_nonmatching();
    @(negedge clk);
    m0_fwd = mk_fwd(32'h01000000, 32'd0, 4'h0, 1'b1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_checks++;
      if (s_fwd !== 69'd0 || busy !== 1'b0 || m0_ret !== 33'd0) begin
        n_fail++;
        $display("FAIL nonmatch: s_fwd=%h busy=%b m0_ret=%h, required 0 0 0", s_fwd, busy, m0_ret);
      end
    end
    n_checks++;
    if (grant !== 1'b1) begin
      n_fail++;
      $display("FAIL nonmatch_grant: got %b, required 1", grant);
    end
    m0_fwd = 69'd0;
  endtask

  task automatic test_timeout();
    int   n;
    int   nvalid;
    exp_t e;
    slave_delay = -1;
    for (int i = 0; i < 300; i++) begin
      e.port = 1'b0; e.data = 32'hDEADBEEF; exp_q.push_back(e);
    end
    @(negedge clk);
    m0_fwd = mk_fwd(32'h00000020, 32'd0, 4'h0, 1'b1);
    n      = 0;
    nvalid = 0;
    for (int c = 0; c < 12000 && n < 300; c++) begin
      @(negedge clk);
      if (n == 0 && s_fwd[32] === 1'b1) nvalid++;
      if (m0_ret[32] === 1'b1) begin
        n++;
        if (n == 1) begin
          n_checks++;
          if (nvalid != 16 || tmo_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL timeout_first: busy_cycles=%0d count=%h, required 16 01", nvalid, tmo_cnt);
          end
        end
        if (n == 254 || n == 255 || n == 300) begin
          n_checks++;
          if (tmo_cnt !== ((n == 254) ? 8'hFE : 8'hFF)) begin
            n_fail++;
            $display("FAIL timeout_sat_%0d: got %h, required %h", n, tmo_cnt,
                     (n == 254) ? 8'hFE : 8'hFF);
          end
        end
        if (n == 300) m0_fwd = 69'd0;
      end
    end
    m0_fwd = 69'd0;
    n_checks++;
    if (n != 300) begin
      n_fail++;
      $display("FAIL timeout_count_resp: got %0d responses, required 300", n);
    end
  endtask

  task automatic test_reset_mid();
    slave_delay = -1;
    @(negedge clk);
    m1_fwd = mk_fwd(32'h00000040, 32'd0, 4'h0, 1'b1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || s_fwd[32] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy: busy=%b s_valid=%b, required 1 1", busy, s_fwd[32]);
    end
    #2;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (m0_ret !== 33'd0 || m1_ret !== 33'd0 || s_fwd !== 69'd0 || busy !== 1'b0 ||
        grant !== 1'b0 || tmo_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_async_reset: m0=%h m1=%h s=%h busy=%b grant=%b tmo=%h, required all 0",
               m0_ret, m1_ret, s_fwd, busy, grant, tmo_cnt);
    end
    m1_fwd = 69'd0;
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || s_fwd !== 69'd0) begin
        n_fail++;
        $display("FAIL mid_after_release: busy=%b s_fwd=%h, required 0 0", busy, s_fwd);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_alternation();
    test_read();
    test_write();
    test_nonmatching();
    test_timeout();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_responses: %0d left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
